skid_reg: RTL and testbench

Parametrised two-entry pipeline register (main + skid) with a valid/ready handshake, synchronous flush and an output-enable-gated data bus. It replaces the plain enable-controlled latch registers used between multicycle datapath stages. It decouples a producer stage from a consumer stage that may stall, and sustains one transfer per cycle. `inReady` is fully registered, so there is no combinational path from `outReady` to `inReady`.

---
 rtl/skid_reg.sv | 111 +++++++++++
 tb/tb_skid_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/skid_reg.sv
// skid_reg: two-entry pipeline register (main + skid) with a valid/ready
// handshake, synchronous flush and an output-enable-gated data bus.
// inReady, outValid and count come straight from registered state, so there
// is no combinational path from outReady to inReady.
// Build option: define SKID_REG_TRISTATE_EN to drive outData to high-Z while
// outEna is low (shared internal bus); otherwise the bus is forced to zero.
module skid_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    input  logic             outEna,
    output logic [WIDTH-1:0] outData,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             accept;
    logic             pop;

    // Handshake flags and occupancy decoded from the state register only.
    always_comb begin
        inReady  = (state_q != FULL);
        outValid = (state_q != EMPTY);
        accept   = inValid & inReady;
        pop      = outValid & outReady;
        case (state_q)
            BUSY:    count = 2'd1;
            FULL:    count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    // Next-state and data-register updates; mainData always holds the oldest entry.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Everything held is discarded; a same-cycle pop still completes,
            // a same-cycle accept is dropped and the data registers keep their contents.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = BUSY;
                        main_data_d = inData;
                    end
                end
                BUSY: begin
                    if (accept && pop) begin
                        main_data_d = inData;
                    end else if (accept) begin
                        state_d     = FULL;
                        skid_data_d = inData;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // inReady is low here, so only a pop can move the state.
                    if (pop) begin
                        state_d     = BUSY;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and data registers; reset discards all entries and wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= RESET_VALUE;
            skid_data_q <= RESET_VALUE;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef SKID_REG_TRISTATE_EN
    // Release the shared bus when not enabled.
    assign outData = outEna ? main_data_q : {WIDTH{1'bz}};
`else
    // No internal tristates: park the bus at zero when not enabled.
    assign outData = outEna ? main_data_q : {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_skid_reg.sv
// Directed testbench for skid_reg with hand-computed expected values.
module tb_skid_reg;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst, flush, inValid, inReady, outValid, outReady, outEna;
    logic [W-1:0]  inData, outData;
    logic [1:0]    count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic [W-1:0] pop_q[$];

    skid_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(inValid), .inReady(inReady), .inData(inData),
        .outValid(outValid), .outReady(outReady), .outEna(outEna),
        .outData(outData), .count(count)
    );

    always #5 clk = ~clk;

    // Four-state compare so high-Z expectations are checked exactly.
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Record any transfer completing at the coming edge, then advance one cycle.
    task automatic step();
        #1;
        if (!rst && outValid && outReady) begin
            n_pop++;
            pop_q.push_back(outData);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        inValid = 1'b1;
        inData  = d;
        step();
        inValid = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0;
        outReady = 1'b0; outEna = 1'b0;
        step(); step();
        rst = 1'b0; outEna = 1'b1;
        #1;
        chk("rst_data",    outData,  RV);
        chk("rst_valid",   outValid, 0);
        chk("rst_ready",   inReady,  1);
        chk("rst_count",   count,    0);

        // Streaming: one word per cycle, occupancy stays at one.
        outReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            inValid = 1'b1;
            inData  = i;
            #1 chk($sformatf("str_ready%0d", i), inReady, 1);
            step();
            chk($sformatf("str_data%0d", i), outData, i);
            chk($sformatf("str_cnt%0d", i),  count,   1);
        end
        inValid = 1'b0;
        step();
        chk("str_drain_cnt", count, 0);
        chk("str_pops",      n_pop, 4);

        // Back-pressure: A and B fill both entries, C waits at the producer.
        outReady = 1'b0;
        base = pop_q.size();
        push(32'hA);
        chk("bp_cnt1", count, 1);
        push(32'hB);
        chk("bp_cnt2",  count,   2);
        chk("bp_ready", inReady, 0);
        inValid = 1'b1; inData = 32'hC;
        step();
        chk("bp_hold_cnt",  count,   2);
        chk("bp_hold_data", outData, 32'hA);
        outReady = 1'b1;
        step();
        chk("bp_pop_main",  outData, 32'hB);
        chk("bp_pop_ready", inReady, 1);
        chk("bp_pop_cnt",   count,   1);
        step();
        chk("bp_c_data", outData, 32'hC);
        chk("bp_c_cnt",  count,   1);
        inValid = 1'b0;
        step();
        chk("bp_empty", count, 0);
        chk("bp_ord0", pop_q[base],   32'hA);
        chk("bp_ord1", pop_q[base+1], 32'hB);
        chk("bp_ord2", pop_q[base+2], 32'hC);

        // Flush from FULL with a pop and an offer in the same cycle.
        outReady = 1'b0;
        push(32'hA);
        push(32'hB);
        chk("fl_full", count, 2);
        base = n_pop;
        flush = 1'b1; outReady = 1'b1; inValid = 1'b1; inData = 32'h55;
        step();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        chk("fl_pop",    n_pop - base,          1);
        chk("fl_popdat", pop_q[pop_q.size()-1], 32'hA);
        chk("fl_cnt",    count,                 0);
        chk("fl_valid",  outValid,              0);
        chk("fl_ready",  inReady,               1);
        chk("fl_keep",   outData,               32'hA);

        // Output gating: the bus follows outEna, the handshake does not.
        push(32'h1234);
        outEna = 1'b0;
        #1;
`ifdef SKID_REG_TRISTATE_EN
        chk("gate_data", outData, {W{1'bz}});
`else
        chk("gate_data", outData, 32'h0);
`endif
        chk("gate_valid", outValid, 1);
        base = n_pop;
        outReady = 1'b1;
        step();
        chk("gate_pop", n_pop - base, 1);
        chk("gate_cnt", count, 0);
        outReady = 1'b0; outEna = 1'b1;

        // Reset mid-operation from FULL with a concurrent outReady.
        push(32'h11);
        push(32'h22);
        chk("rm_full", count, 2);
        base = n_pop;
        rst = 1'b1; outReady = 1'b1;
        step();
        rst = 1'b0; outReady = 1'b0;
        chk("rm_nopop", n_pop - base, 0);
        chk("rm_cnt",   count,        0);
        chk("rm_valid", outValid,     0);
        chk("rm_main",  dut.main_data_q, RV);
        chk("rm_skid",  dut.skid_data_q, RV);
        chk("rm_data",  outData,      RV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
